// File: rtl/mean_pkg.sv
// Shared width and depth helpers for the multi-channel moving-average filter.
// Build option: MEAN_MC_ROUND_EN selects round-half-up averaging in mean_mc.
package mean_pkg;

   // Running sum must hold 2^LOG2_WIN samples of IN_W bits each.
   function automatic int sum_width(input int in_w, input int log2_win);
      return in_w + log2_win;
   endfunction

   // A single channel still needs a one-bit index port.
   function automatic int ch_width(input int ch);
      return (ch > 1) ? $clog2(ch) : 1;
   endfunction

   // Number of history entries per channel.
   function automatic int win_depth(input int log2_win);
      return 1 << log2_win;
   endfunction

   // Write pointer width; a one-entry window still gets a one-bit pointer.
   function automatic int ptr_width(input int log2_win);
      return (log2_win > 0) ? log2_win : 1;
   endfunction

endpackage

// File: rtl/mean_mc_if.sv
// Sample/result bus of mean_mc.
// Handshake: valid-only, no backpressure. A sample is taken on every rising
// edge where in_valid=1, clear=0 and in_ch names an existing channel; the
// matching result is presented with out_valid=1 for exactly one cycle after
// that edge. out_ch/out/out_full hold their value while out_valid=0.
interface mean_mc_if #(
   parameter int IN_W  = 8,
   parameter int OUT_W = 8,
   parameter int CH_W  = 1
);
   logic             clear;
   logic             in_valid;
   logic [CH_W-1:0]  in_ch;
   logic [IN_W-1:0]  in;
   logic             out_valid;
   logic [CH_W-1:0]  out_ch;
   logic [OUT_W-1:0] out;
   logic             out_full;

   modport master (
      output clear, in_valid, in_ch, in,
      input  out_valid, out_ch, out, out_full
   );

   modport slave (
      input  clear, in_valid, in_ch, in,
      output out_valid, out_ch, out, out_full
   );
endinterface

// File: rtl/mean_ring.sv
// One channel's sample history: ring buffer, write pointer and fill counter.
// old_data is the entry about to be overwritten, so the caller can subtract
// it from the running sum in the same cycle the new sample is written.
module mean_ring
   import mean_pkg::*;
#(
   parameter int IN_W     = 8,
   parameter int LOG2_WIN = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clear,
   input  logic            wr_en,
   input  logic [IN_W-1:0] wr_data,
   output logic [IN_W-1:0] old_data,
   output logic            fills_on_wr
);
   localparam int WIN    = win_depth(LOG2_WIN);
   localparam int PTR_W  = ptr_width(LOG2_WIN);
   localparam int FILL_W = LOG2_WIN + 1;

   logic [IN_W-1:0]   ring_q [WIN];
   logic [PTR_W-1:0]  ptr_q;
   logic [FILL_W-1:0] fill_q;

   // Select the entry under the write pointer (the oldest sample).
   always_comb begin
      old_data = '0;
      for (int i = 0; i < WIN; i++) begin
         if (ptr_q == PTR_W'(i)) old_data = ring_q[i];
      end
   end

   // A write now makes the window full if it already holds WIN-1 samples.
   assign fills_on_wr = (fill_q >= FILL_W'(WIN - 1));

   // History update: overwrite oldest entry, advance pointer, count fill.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < WIN; i++) ring_q[i] <= '0;
         ptr_q  <= '0;
         fill_q <= '0;
      end else if (clear) begin
         for (int i = 0; i < WIN; i++) ring_q[i] <= '0;
         ptr_q  <= '0;
         fill_q <= '0;
      end else if (wr_en) begin
         for (int i = 0; i < WIN; i++) begin
            if (ptr_q == PTR_W'(i)) ring_q[i] <= wr_data;
         end
         if (ptr_q == PTR_W'(WIN - 1)) ptr_q <= '0;
         else                          ptr_q <= ptr_q + PTR_W'(1);
         if (fill_q != FILL_W'(WIN))   fill_q <= fill_q + FILL_W'(1);
      end
   end
endmodule

// File: rtl/mean_mc.sv
// Multi-channel power-of-two moving-average filter with registered output.
// Build option: define MEAN_MC_ROUND_EN for round-half-up averaging;
// otherwise the average truncates.
module mean_mc
   import mean_pkg::*;
#(
   parameter int IN_W     = 8,
   parameter int OUT_W    = 8,
   parameter int LOG2_WIN = 3,
   parameter int CH       = 2
) (
   input logic      clk,
   input logic      rst,
   mean_mc_if.slave bus
);
   localparam int SUM_W = sum_width(IN_W, LOG2_WIN);
   localparam int CH_W  = ch_width(CH);
   localparam logic [SUM_W:0] HALF = (SUM_W+1)'(win_depth(LOG2_WIN) / 2);

   logic [SUM_W-1:0] sum_q [CH];
   logic [IN_W-1:0]  old_ch [CH];
   logic [CH-1:0]    full_ch;
   logic [CH-1:0]    wr_en;
   logic             ch_ok;
   logic             accept;
   logic [IN_W-1:0]  old_sel;
   logic [SUM_W-1:0] sum_sel;
   logic             full_sel;
   logic [SUM_W-1:0] sum_new;
   logic [SUM_W:0]   sum_rnd;
   logic [OUT_W-1:0] out_d;

   // Out-of-range channels and samples coinciding with clear are dropped.
   assign ch_ok  = ({1'b0, bus.in_ch} < (CH_W+1)'(CH));
   assign accept = bus.in_valid & ~bus.clear & ch_ok;

   genvar g;
   generate
      for (g = 0; g < CH; g++) begin : g_ch
         assign wr_en[g] = accept && (bus.in_ch == CH_W'(g));
         mean_ring #(
            .IN_W     (IN_W),
            .LOG2_WIN (LOG2_WIN)
         ) u_ring (
            .clk         (clk),
            .rst         (rst),
            .clear       (bus.clear),
            .wr_en       (wr_en[g]),
            .wr_data     (bus.in),
            .old_data    (old_ch[g]),
            .fills_on_wr (full_ch[g])
         );
      end
   endgenerate

   // Route the addressed channel's sum, oldest sample and fill state.
   always_comb begin
      old_sel  = '0;
      sum_sel  = '0;
      full_sel = 1'b0;
      for (int c = 0; c < CH; c++) begin
         if (bus.in_ch == CH_W'(c)) begin
            old_sel  = old_ch[c];
            sum_sel  = sum_q[c];
            full_sel = full_ch[c];
         end
      end
   end

   // The sum always contains the oldest sample, so the subtraction cannot wrap.
   assign sum_new = sum_sel - SUM_W'(old_sel) + SUM_W'(bus.in);

`ifdef MEAN_MC_ROUND_EN
   assign sum_rnd = {1'b0, sum_new} + HALF;
`else
   assign sum_rnd = {1'b0, sum_new};
`endif

   // Fit the IN_W-bit average to OUT_W: zero-extend or keep its MSBs.
   generate
      if (OUT_W >= IN_W) begin : g_out_wide
         assign out_d = OUT_W'(IN_W'(sum_rnd >> LOG2_WIN));
      end else begin : g_out_narrow
         assign out_d = OUT_W'(sum_rnd >> (LOG2_WIN + IN_W - OUT_W));
      end
   endgenerate

   // Per-channel running sums.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < CH; c++) sum_q[c] <= '0;
      end else if (bus.clear) begin
         for (int c = 0; c < CH; c++) sum_q[c] <= '0;
      end else begin
         for (int c = 0; c < CH; c++) begin
            if (wr_en[c]) sum_q[c] <= sum_new;
         end
      end
   end

   // Result register: one strobe per accepted sample, data held otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.out_valid <= 1'b0;
         bus.out_ch    <= '0;
         bus.out       <= '0;
         bus.out_full  <= 1'b0;
      end else begin
         bus.out_valid <= accept;
         if (accept) begin
            bus.out_ch   <= bus.in_ch;
            bus.out      <= out_d;
            bus.out_full <= full_sel;
         end
      end
   end
endmodule

// File: tb/tb_mean_mc.sv
// Self-checking bench for mean_mc: directed scenarios plus random traffic
// against a queue-based window model. Honours MEAN_MC_ROUND_EN.
module tb_mean_mc;
   localparam int IN_W  = 8;
   localparam int OUT_W = 8;
   localparam int L     = 3;
   localparam int CH    = 3;
   localparam int CH_W  = 2;
   localparam int WIN   = 1 << L;
   localparam int EW    = CH_W + 1 + OUT_W;

   logic clk;
   logic rst;

   mean_mc_if #(.IN_W(IN_W), .OUT_W(OUT_W), .CH_W(CH_W)) bus ();

   mean_mc #(.IN_W(IN_W), .OUT_W(OUT_W), .LOG2_WIN(L), .CH(CH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // scoreboard state
   logic [EW-1:0] exp_q[$];
   int            hist [CH][$];
   int            cnt  [CH];
   int            n_checks = 0;
   int            n_pass   = 0;
   logic [CH_W-1:0]  last_ch   = '0;
   logic [OUT_W-1:0] last_out  = '0;
   logic             last_full = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
   endtask

   // reference model: each channel window is a queue of the last WIN samples
   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         hist[c].delete();
         for (int i = 0; i < WIN; i++) hist[c].push_back(0);
         cnt[c] = 0;
      end
   endtask

   task automatic model_push(input int ch, input int d);
      int s;
      int avg;
      int rnd;
      logic full;
      void'(hist[ch].pop_front());
      hist[ch].push_back(d);
      cnt[ch]++;
      s = 0;
      foreach (hist[ch][i]) s += hist[ch][i];
`ifdef MEAN_MC_ROUND_EN
      rnd = WIN / 2;
`else
      rnd = 0;
`endif
      avg  = (s + rnd) / WIN;
      full = (cnt[ch] >= WIN);
      exp_q.push_back({CH_W'(ch), full, OUT_W'(avg)});
   endtask

   // driver: present one cycle of inputs, then check the registered result
   task automatic step(input logic v, input int ch, input int d, input logic clr);
      logic          acc;
      logic [EW-1:0] e;
      bus.in_valid = v;
      bus.in_ch    = CH_W'(ch);
      bus.in       = IN_W'(d);
      bus.clear    = clr;
      acc = v && !clr && (ch < CH);
      if (acc) model_push(ch, d);
      if (clr) model_reset();
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.clear    = 1'b0;
      check("out_valid", 32'(bus.out_valid), 32'(acc));
      if (acc) begin
         e = exp_q.pop_front();
         last_ch   = e[EW-1 -: CH_W];
         last_full = e[OUT_W];
         last_out  = e[OUT_W-1:0];
      end
      check("out_ch", 32'(bus.out_ch), 32'(last_ch));
      check("out", 32'(bus.out), 32'(last_out));
      check("out_full", 32'(bus.out_full), 32'(last_full));
   endtask

   initial begin
      int one_exp;
      rst          = 1'b1;
      bus.clear    = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_ch    = '0;
      bus.in       = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 32'(bus.out_valid), 0);
      check("rst_ch", 32'(bus.out_ch), 0);
      check("rst_out", 32'(bus.out), 0);
      check("rst_full", 32'(bus.out_full), 0);
      rst = 1'b0;

      // fill ch0 with 128: ramp 16..128, full only on the 8th
      repeat (WIN) step(1'b1, 0, 128, 1'b0);
      check("fill_out", 32'(bus.out), 128);
      check("fill_full", 32'(bus.out_full), 1);

      // drain with zeros across the pointer wrap: 112..0, full stays set
      repeat (WIN) step(1'b1, 0, 0, 1'b0);
      check("drain_out", 32'(bus.out), 0);
      check("drain_full", 32'(bus.out_full), 1);

      // alternating channels back-to-back
      for (int i = 0; i < 16; i++) step(1'b1, i % 2, (i % 2) ? 200 : 100, 1'b0);
      check("alt_ch1_out", 32'(bus.out), 200);
      check("alt_ch1_tag", 32'(bus.out_ch), 1);

      // clear with a simultaneous sample, then restart ch0
      step(1'b1, 0, 55, 1'b1);
      step(1'b1, 0, 80, 1'b0);
      check("clr_out", 32'(bus.out), 10);
      check("clr_full", 32'(bus.out_full), 0);
      step(1'b1, 3, 77, 1'b0);

      // rounding behaviour and the top of the range
      step(1'b0, 0, 0, 1'b1);
      repeat (4) step(1'b1, 1, 1, 1'b0);
`ifdef MEAN_MC_ROUND_EN
      one_exp = 1;
`else
      one_exp = 0;
`endif
      check("round_out", 32'(bus.out), 32'(one_exp));
      repeat (WIN) step(1'b1, 2, 255, 1'b0);
      check("max_out", 32'(bus.out), 255);

      // asynchronous reset between edges
      step(1'b1, 0, 33, 1'b0);
      #3;
      rst = 1'b1;
      #1;
      check("arst_valid", 32'(bus.out_valid), 0);
      check("arst_out", 32'(bus.out), 0);
      check("arst_full", 32'(bus.out_full), 0);
      check("arst_ch", 32'(bus.out_ch), 0);
      #1;
      rst = 1'b0;
      model_reset();
      exp_q.delete();
      last_ch   = '0;
      last_out  = '0;
      last_full = 1'b0;
      step(1'b1, 0, 64, 1'b0);
      check("arst_next_out", 32'(bus.out), 8);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 255),
              $urandom_range(0, 39) == 0);
      end

      check("exp_q_empty", 32'(exp_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
